// File: rtl/mult_parity_core.sv
// ---------------------------------------------------------------------------
// mult_parity_core
//
// Sequential signed multiplier with even-parity checking on both operands.
// Operands are accepted over a req/ack handshake. If either operand parity
// bit disagrees with the XOR of its data bits the operation is rejected: the
// block reports result = 0 with arg_parity_error set. Otherwise the full
// 2*DATA_W-bit signed product is computed and reported together with its
// parity.
//
// Default build: iterative unsigned shift-add on operand magnitudes, one
// multiplier bit per cycle, DATA_W busy cycles, sign applied at the end.
// Optional build (define MULT_FAST_EN): a single busy cycle that uses a
// combinational signed multiply. Handshake, error path and outputs are the
// same in both builds.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active-high
//   arg_a            in   [DATA_W-1:0] operand A, two's complement
//   arg_a_parity     in   even parity bit for arg_a
//   arg_b            in   [DATA_W-1:0] operand B, two's complement
//   arg_b_parity     in   even parity bit for arg_b
//   req              in   request, args held stable until ack
//   ack              out  one-cycle pulse, operands captured
//   result           out  [2*DATA_W-1:0] signed product, 0 on parity error
//   result_parity    out  XOR of all result bits
//   arg_parity_error out  either operand parity was wrong
//   result_rdy       out  one-cycle pulse, result outputs updated
// ---------------------------------------------------------------------------
module mult_parity_core #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    input  logic                  req,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  arg_parity_error,
    output logic                  result_rdy
);

    localparam int RES_W = 2 * DATA_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             err_q;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] done_value;
    logic             pa_err;
    logic             pb_err;

    // A parity bit is correct when it equals the XOR of its data bits.
    assign pa_err = arg_a_parity ^ (^arg_a);
    assign pb_err = arg_b_parity ^ (^arg_b);

`ifdef MULT_FAST_EN
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
`else
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  counter;
    logic [RES_W-1:0]  mcand;
    logic [DATA_W:0]   mplier;
    logic              neg_q;

    // Magnitude is DATA_W+1 bits wide so that -2^(DATA_W-1) maps to
    // +2^(DATA_W-1) without wrapping back to a negative value.
    function automatic logic [DATA_W:0] magnitude(input logic [DATA_W-1:0] v);
        logic [DATA_W:0] ext;
        ext = {v[DATA_W-1], v};
        return v[DATA_W-1] ? (~ext + (DATA_W+1)'(1)) : ext;
    endfunction
`endif

    // Value loaded into the result register when leaving DONE: zero for a
    // rejected operation, otherwise the signed product.
    always_comb begin
        done_value = '0;
        if (!err_q) begin
`ifdef MULT_FAST_EN
            done_value = acc;
`else
            done_value = neg_q ? (~acc + RES_W'(1)) : acc;
`endif
        end
    end

    // Control FSM and datapath. ack and result_rdy default low every cycle
    // so each is a single-cycle pulse. The result outputs are only written
    // in DONE, so they stay stable while the next operation is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ack              <= 1'b0;
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
            err_q            <= 1'b0;
            acc              <= '0;
`ifdef MULT_FAST_EN
            a_q              <= '0;
            b_q              <= '0;
`else
            counter          <= '0;
            mcand            <= '0;
            mplier           <= '0;
            neg_q            <= 1'b0;
`endif
        end else begin
            ack        <= 1'b0;
            result_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        ack   <= 1'b1;
                        err_q <= pa_err | pb_err;
                        acc   <= '0;
`ifdef MULT_FAST_EN
                        a_q   <= arg_a;
                        b_q   <= arg_b;
`else
                        counter <= '0;
                        mcand   <= {{(DATA_W-1){1'b0}}, magnitude(arg_a)};
                        mplier  <= magnitude(arg_b);
                        neg_q   <= arg_a[DATA_W-1] ^ arg_b[DATA_W-1];
`endif
                        state <= (pa_err | pb_err) ? DONE : BUSY;
                    end
                end

                BUSY: begin
`ifdef MULT_FAST_EN
                    // Both operands sign-extended to full width; the low
                    // RES_W bits of the product are the exact signed result.
                    acc   <= {{DATA_W{a_q[DATA_W-1]}}, a_q}
                           * {{DATA_W{b_q[DATA_W-1]}}, b_q};
                    state <= DONE;
`else
                    // One multiplier bit per cycle, LSB first. The shifted
                    // multiplicand tracks the weight of the current bit.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_STEP) begin
                        state <= DONE;
                    end
`endif
                end

                DONE: begin
                    result           <= done_value;
                    result_parity    <= ^done_value;
                    arg_parity_error <= err_q;
                    result_rdy       <= 1'b1;
                    state            <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_parity_core.sv
// ---------------------------------------------------------------------------
// tb_mult_parity_core
//
// Directed testbench for mult_parity_core at DATA_W = 16. A table of operand
// records with hand-computed products, parities and latencies is applied
// one operation at a time; hand-written sequences then cover reset in the
// middle of a multiply and back-to-back requests with req held high.
// ---------------------------------------------------------------------------
module tb_mult_parity_core;

    localparam int DATA_W = 16;

    logic                clk;
    logic                rst;
    logic [DATA_W-1:0]   arg_a;
    logic                arg_a_parity;
    logic [DATA_W-1:0]   arg_b;
    logic                arg_b_parity;
    logic                req;
    logic                ack;
    logic [2*DATA_W-1:0] result;
    logic                result_parity;
    logic                arg_parity_error;
    logic                result_rdy;

    int checks;
    int errors;
    logic [2*DATA_W-1:0] prev_result;

    typedef struct {
        logic [DATA_W-1:0]   a;
        logic                ap;
        logic [DATA_W-1:0]   b;
        logic                bp;
        logic [2*DATA_W-1:0] res;
        logic                rp;
        logic                err;
        int                  lat;
    } vec_t;

    vec_t vecs[11];

    mult_parity_core #(.DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .req              (req),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .arg_parity_error (arg_parity_error),
        .result_rdy       (result_rdy)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one request from a negedge, then follows the operation until
    // result_rdy, checking ack timing, latency, outputs and hold behaviour.
    task automatic applyStimulus(input int idx, input vec_t v);
        int n;
        bit seen;
        @(negedge clk);
        arg_a        = v.a;
        arg_a_parity = v.ap;
        arg_b        = v.b;
        arg_b_parity = v.bp;
        req          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput($sformatf("v%0d_ack", idx), 64'(ack), 64'd1);
        checkOutput($sformatf("v%0d_rdy_early", idx), 64'(result_rdy), 64'd0);
        checkOutput($sformatf("v%0d_result_held", idx), 64'(result), 64'(prev_result));
        req = 1'b0;
        seen = 1'b0;
        n = 1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                checkOutput($sformatf("v%0d_ack_pulse", idx), 64'(ack), 64'd0);
            end
            if (result_rdy) begin
                seen = 1'b1;
            end
        end
        checkOutput($sformatf("v%0d_latency", idx), 64'(n), 64'(v.lat));
        checkOutput($sformatf("v%0d_result", idx), 64'(result), 64'(v.res));
        checkOutput($sformatf("v%0d_result_parity", idx), 64'(result_parity), 64'(v.rp));
        checkOutput($sformatf("v%0d_parity_error", idx), 64'(arg_parity_error), 64'(v.err));
        @(negedge clk);
        checkOutput($sformatf("v%0d_rdy_pulse", idx), 64'(result_rdy), 64'd0);
        checkOutput($sformatf("v%0d_result_hold", idx), 64'(result), 64'(v.res));
        prev_result = v.res;
    endtask

    initial begin
        int acks;
        int rdys;
        int last_ack;
        int rdy_seen;
        logic [2*DATA_W-1:0] bb_exp[3];

        checks       = 0;
        errors       = 0;
        prev_result  = '0;
        rst          = 1'b1;
        req          = 1'b0;
        arg_a        = '0;
        arg_a_parity = 1'b0;
        arg_b        = '0;
        arg_b_parity = 1'b0;

        // {a, a parity, b, b parity, result, result parity, error, latency}
        vecs[0]  = '{16'h0003, 1'b0, 16'hFFFE, 1'b1, 32'hFFFFFFFA, 1'b0, 1'b0, 18};
        vecs[1]  = '{16'h0005, 1'b1, 16'h0002, 1'b1, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[2]  = '{16'h0001, 1'b0, 16'h0001, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[3]  = '{16'h8000, 1'b1, 16'h8000, 1'b1, 32'h40000000, 1'b1, 1'b0, 18};
        // 0xC0008000 has three set bits, so its parity is 1.
        vecs[4]  = '{16'h7FFF, 1'b1, 16'h8000, 1'b1, 32'hC0008000, 1'b1, 1'b0, 18};
        vecs[5]  = '{16'h0000, 1'b0, 16'hFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0, 18};
        vecs[6]  = '{16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 32'h00000001, 1'b1, 1'b0, 18};
        vecs[7]  = '{16'h0002, 1'b1, 16'h0007, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[8]  = '{16'h1234, 1'b1, 16'h0010, 1'b1, 32'h00012340, 1'b1, 1'b0, 18};
        vecs[9]  = '{16'h8000, 1'b1, 16'h0001, 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 18};
        vecs[10] = '{16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 32'h3FFF0001, 1'b1, 1'b0, 18};

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", 64'(ack), 64'd0);
        checkOutput("reset_rdy", 64'(result_rdy), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_parity", 64'(result_parity), 64'd0);
        checkOutput("reset_error", 64'(arg_parity_error), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Reset during the 5th busy cycle: outputs clear at once, the
        // in-flight operation never reports.
        @(negedge clk);
        arg_a        = 16'h0003;
        arg_a_parity = 1'b0;
        arg_b        = 16'h0005;
        arg_b_parity = 1'b0;
        req          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midop_reset_result", 64'(result), 64'd0);
        checkOutput("midop_reset_flags",
                    64'({ack, result_rdy, result_parity, arg_parity_error}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (result_rdy) rdy_seen++;
        end
        checkOutput("midop_reset_no_rdy", 64'(rdy_seen), 64'd0);
        prev_result = '0;
        applyStimulus(11, vecs[0]);

        // Back-to-back with req held high: 2*3, then the args switch to
        // 4*5 right after the first ack and are picked up by later ops.
        bb_exp[0] = 32'd6;
        bb_exp[1] = 32'd20;
        bb_exp[2] = 32'd20;
        @(negedge clk);
        arg_a        = 16'h0002;
        arg_a_parity = 1'b1;
        arg_b        = 16'h0003;
        arg_b_parity = 1'b0;
        req          = 1'b1;
        acks     = 0;
        rdys     = 0;
        last_ack = 0;
        for (int c = 0; c < 100 && rdys < 3; c++) begin
            @(negedge clk);
            if (ack) begin
                if (acks > 0) begin
                    checkOutput($sformatf("b2b_ack_spacing%0d", acks), 64'(c - last_ack), 64'd18);
                end
                last_ack = c;
                acks++;
                if (acks == 1) begin
                    arg_a        = 16'h0004;
                    arg_a_parity = 1'b1;
                    arg_b        = 16'h0005;
                    arg_b_parity = 1'b0;
                end
            end
            if (result_rdy) begin
                checkOutput($sformatf("b2b_result%0d", rdys), 64'(result), 64'(bb_exp[rdys]));
                checkOutput($sformatf("b2b_error%0d", rdys), 64'(arg_parity_error), 64'd0);
                rdys++;
                if (rdys == 3) req = 1'b0;
            end
        end
        checkOutput("b2b_rdy_count", 64'(rdys), 64'd3);
        checkOutput("b2b_ack_count", 64'(acks), 64'd3);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
